// File: rtl/mine_pkg.sv
// Shared types and helpers for the mine placer.
// Optional first-click protection: MINE_PLACER_SAFE_START_EN.
package mine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0] DEF_MULT = 16'd25173;
  localparam logic [15:0] DEF_INC  = 16'd13849;

  function automatic int cells_f(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int idx_w_f(input int cells);
    return $clog2(cells);
  endfunction

  function automatic int cnt_w_f(input int cells);
    return $clog2(cells + 1);
  endfunction

endpackage

// File: rtl/mine_placer_lcg_core.sv
// LCG state register: X <= a*X + c on advance.
// Exposes the upper bits of the next value as the cell candidate.
module lcg_core #(
  parameter int W  = 16,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [W-1:0]  seed,
  input  logic [W-1:0]  mult,
  input  logic [W-1:0]  inc,
  output logic [IW-1:0] cand
);

  logic [W-1:0] x;
  logic [W-1:0] nxt;

  // Low W bits of the product are all the generator ever needs.
  assign nxt  = mult * x + inc;
  assign cand = nxt[W-1 -: IW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
    end else if (load) begin
      x <= seed;
    end else if (advance) begin
      x <= nxt;
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Places exactly N distinct mines using an LCG with rejection.
// Define MINE_PLACER_SAFE_START_EN to reserve one never-mined cell.
module mine_placer
  import mine_pkg::*;
#(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int LCG_W     = 16,
  parameter int MAX_TRIES = 1024,
  parameter int CELLS     = cells_f(ROWS, COLS),
  parameter int IDX_W     = idx_w_f(CELLS),
  parameter int CNT_W     = cnt_w_f(CELLS)
) (
  input  logic             in_clka,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic [LCG_W-1:0] in_seed,
  input  logic [LCG_W-1:0] in_mult,
  input  logic [LCG_W-1:0] in_increment,
  input  logic [CNT_W-1:0] in_mines_num,
`ifdef MINE_PLACER_SAFE_START_EN
  input  logic [IDX_W-1:0] in_safe_idx,
`endif
  output logic [CELLS-1:0] out_mines,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_error
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
`ifdef MINE_PLACER_SAFE_START_EN
  localparam int MAX_N = CELLS - 1;
`else
  localparam int MAX_N = CELLS;
`endif

  state_t             state;
  logic [LCG_W-1:0]   a_q;
  logic [LCG_W-1:0]   c_q;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   cnt;
  logic [TRY_W-1:0]   tries;
  logic [IDX_W-1:0]   idx;
  logic [CELLS-1:0]   hit;
  logic               go;
  logic               bad;
  logic               accept;
  logic               last;

  assign go = (state == IDLE) && in_start;

  lcg_core #(
    .W  (LCG_W),
    .IW (IDX_W)
  ) u_lcg (
    .clk     (in_clka),
    .rst     (in_reset),
    .load    (go),
    .advance (state == RUN),
    .seed    (in_seed),
    .mult    (a_q),
    .inc     (c_q),
    .cand    (idx)
  );

  assign hit = {{(CELLS-1){1'b0}}, 1'b1} << idx;

`ifdef MINE_PLACER_SAFE_START_EN
  logic [IDX_W-1:0] safe_q;

  assign bad = (int'(in_mines_num) > MAX_N)
            || (int'(in_safe_idx) >= CELLS);
  assign accept = (int'(idx) < CELLS) && !out_mines[idx]
               && (idx != safe_q);

  always_ff @(posedge in_clka or posedge in_reset) begin
    if (in_reset) begin
      safe_q <= '0;
    end else if (go) begin
      safe_q <= in_safe_idx;
    end
  end
`else
  assign bad = int'(in_mines_num) > MAX_N;
  assign accept = (int'(idx) < CELLS) && !out_mines[idx];
`endif

  assign last = (cnt + CNT_W'(1)) == n_q;

  always_ff @(posedge in_clka or posedge in_reset) begin
    if (in_reset) begin
      state     <= IDLE;
      out_mines <= '0;
      out_busy  <= 1'b0;
      out_done  <= 1'b0;
      out_error <= 1'b0;
      a_q       <= '0;
      c_q       <= '0;
      n_q       <= '0;
      cnt       <= '0;
      tries     <= '0;
    end else begin
      out_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_start) begin
            a_q       <= in_mult;
            c_q       <= in_increment;
            n_q       <= in_mines_num;
            out_mines <= '0;
            out_error <= 1'b0;
            cnt       <= '0;
            tries     <= '0;
            if (bad) begin
              out_error <= 1'b1;
              state     <= DONE;
            end else if (in_mines_num == '0) begin
              state <= DONE;
            end else begin
              out_busy <= 1'b1;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          tries <= tries + TRY_W'(1);
          if (accept) begin
            out_mines <= out_mines | hit;
            cnt       <= cnt + CNT_W'(1);
          end
          // A final accept wins over exhaustion on the same attempt.
          if (accept && last) begin
            out_busy <= 1'b0;
            state    <= DONE;
          end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
            out_error <= 1'b1;
            out_busy  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          out_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer (5x5 board, default LCG constants).
// Safe-cell cases compile in with MINE_PLACER_SAFE_START_EN.
module tb_mine_placer;
  import mine_pkg::*;

  localparam int CELLS = 25;
  localparam int LIMIT = 2000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] seed;
  logic [15:0] mult;
  logic [15:0] inc;
  logic [4:0]  num;
  logic [24:0] mines;
  logic        busy;
  logic        done;
  logic        error;
`ifdef MINE_PLACER_SAFE_START_EN
  logic [4:0]  safe_idx;
`endif

  int n_run;
  int n_fail;
  int cyc;
  logic busy_seen;
  logic [24:0] ref_map;

  mine_placer u_dut (
    .in_clka      (clk),
    .in_reset     (rst),
    .in_start     (start),
    .in_seed      (seed),
    .in_mult      (mult),
    .in_increment (inc),
    .in_mines_num (num),
`ifdef MINE_PLACER_SAFE_START_EN
    .in_safe_idx  (safe_idx),
`endif
    .out_mines    (mines),
    .out_busy     (busy),
    .out_done     (done),
    .out_error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a run; cyc counts edges from the sampling edge to out_done.
  task automatic run(input logic [15:0] s, input logic [15:0] a,
                     input logic [15:0] c, input logic [4:0] n);
    @(negedge clk);
    seed  = s;
    mult  = a;
    inc   = c;
    num   = n;
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    busy_seen = 1'b0;
    #1;
    start = 1'b0;
    mult  = ~a;
    inc   = ~c;
    num   = 5'd3;
    forever begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (done) break;
      if (cyc > LIMIT) begin
        check("timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    check("done_1cyc", {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    seed   = '0;
    mult   = '0;
    inc    = '0;
    num    = '0;
`ifdef MINE_PLACER_SAFE_START_EN
    safe_idx = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mines", {7'd0, mines}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, error}, 32'd0);

    run(16'd1, DEF_MULT, DEF_INC, 5'd0);
    check("n0_lat", cyc, 32'd2);
    check("n0_mines", {7'd0, mines}, 32'd0);
    check("n0_err", {31'd0, error}, 32'd0);
    check("n0_busy", {31'd0, busy_seen}, 32'd0);

    run(16'd1, DEF_MULT, DEF_INC, 5'd26);
    check("n26_err", {31'd0, error}, 32'd1);
    check("n26_mines", {7'd0, mines}, 32'd0);
    check("n26_lat", cyc, 32'd2);
    check("n26_busy", {31'd0, busy_seen}, 32'd0);

`ifndef MINE_PLACER_SAFE_START_EN
    run(16'd1, DEF_MULT, DEF_INC, 5'd25);
    check("full_mines", {7'd0, mines}, 32'h1FFFFFF);
    check("full_err", {31'd0, error}, 32'd0);
    check("full_tries", {31'd0, cyc <= 1026}, 32'd1);
    check("full_busy", {31'd0, busy_seen}, 32'd1);
`endif

    run(16'd0, 16'd1, 16'd0, 5'd8);
    check("stuck_mines", {7'd0, mines}, 32'd1);
    check("stuck_err", {31'd0, error}, 32'd1);
    check("stuck_lat", cyc, 32'd1026);
    repeat (3) @(negedge clk);
    check("stuck_hold", {31'd0, error}, 32'd1);

    run(16'hACE1, DEF_MULT, DEF_INC, 5'd10);
    check("r1_pop", $countones(mines), 32'd10);
    check("r1_err", {31'd0, error}, 32'd0);
    ref_map = mines;
    run(16'hACE1, DEF_MULT, DEF_INC, 5'd10);
    check("r2_same", {7'd0, mines}, {7'd0, ref_map});
    check("r2_pop", $countones(mines), 32'd10);

    @(negedge clk);
    seed  = 16'hACE1;
    mult  = DEF_MULT;
    inc   = DEF_INC;
    num   = 5'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_mines", {7'd0, mines}, 32'd0);
    check("mid_busy0", {31'd0, busy}, 32'd0);
    check("mid_err", {31'd0, error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(16'hACE1, DEF_MULT, DEF_INC, 5'd10);
    check("post_same", {7'd0, mines}, {7'd0, ref_map});
    check("post_err", {31'd0, error}, 32'd0);

`ifdef MINE_PLACER_SAFE_START_EN
    safe_idx = 5'd12;
    run(16'd1, DEF_MULT, DEF_INC, 5'd24);
    check("safe_mines", {7'd0, mines}, 32'h1FFEFFF);
    check("safe_err", {31'd0, error}, 32'd0);
    run(16'd1, DEF_MULT, DEF_INC, 5'd25);
    check("safe_n25", {31'd0, error}, 32'd1);
    check("safe_n25_m", {7'd0, mines}, 32'd0);
    safe_idx = 5'd25;
    run(16'd1, DEF_MULT, DEF_INC, 5'd4);
    check("safe_bad", {31'd0, error}, 32'd1);
    check("safe_bad_m", {7'd0, mines}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
